forwarding_hazard_unit: RTL and testbench
=========================================

# forwarding_hazard_unit

Tracks destination registers of the instructions in the EX and MEM stages of the 5-stage pipeline. Produces the 2-bit select words for the two ALU-operand `mux4` instances at the ID/EX boundary, so each operand takes its value from the register file, the EX/MEM result, the MEM/WB writeback value, or a constant zero. Detects load-use hazards, stalls IF/ID for one cycle and injects a bubble into EX. Sits in the ID stage, directly upstream of the operand muxes.

## Interface

**Parameters**
- `NB_REG`, 5, register-index width
- `NB_SELECT`, 2, operand-mux select width; must match `mux4` `NB_SELECT`

**Ports**
- `i_clk`  in  1  clock; all state updates on the rising edge
- `i_reset`  in  1  asynchronous, active-high reset
- `i_enable`  in  1  pipeline advance enable; 0 freezes all state (debug step mode)
- `i_id_valid`  in  1  ID holds a real instruction
- `i_id_rs`, `i_id_rt`  in  NB_REG  source register indices of the ID instruction
- `i_id_rs_used`, `i_id_rt_used`  in  1  the source is actually read
- `i_id_rd`  in  NB_REG  destination index of the ID instruction
- `i_id_reg_write`  in  1  ID instruction writes `i_id_rd`
- `i_id_mem_read`  in  1  ID instruction is a load
- `i_flush`  in  1  kill the ID instruction (taken branch/jump)
- `o_stall`  out  1  combinational; hold PC and IF/ID this cycle
- `o_fwd_a_sel`, `o_fwd_b_sel`  out  NB_SELECT  registered; selects for the operand A/B `mux4`
- `o_ex_bubble`  out  1  registered; the instruction now in EX is a bubble

## Operation

**Internal state**
- EX tracker: `ex_valid`, `ex_rd`, `ex_rw`, `ex_mr`.
- MEM tracker: `mem_valid`, `mem_rd`, `mem_rw`.

**Select encoding** (matches the operand-mux inputs)
- 00: register file (A input).
- 01: EX/MEM ALU result (B input).
- 10: MEM/WB writeback data, including load data (C input).
- 11: constant zero (D input).

**Per-source select** (computed combinationally in cycle n, for source s)
- Source not used: 00.
- s == 0: 11. This applies even if a tracker targets r0.
- `ex_valid & ex_rw & ex_rd==s & !ex_mr`: 01.
- Otherwise `mem_valid & mem_rw & mem_rd==s`: 10.
- Otherwise: 00.
- EX match has priority over MEM match.
- A tracker with rd == 0 never matches.

**Load-use hazard**
- Raised when `ex_valid & ex_mr & ex_rw & ex_rd!=0` and `ex_rd` equals a used, nonzero rs or rt of a valid ID instruction.
- `o_stall` = hazard & `!i_flush`. Flush wins because the dependent instruction dies anyway.

**Advance** (rising edge with `i_enable`=1)
- MEM tracker ← EX tracker.
- If `i_id_valid & !o_stall & !i_flush`:
  - EX tracker ← ID fields.
  - Selects ← computed values.
  - `o_ex_bubble` ← 0.
- Otherwise:
  - `ex_valid` ← 0.
  - Selects ← 00.
  - `o_ex_bubble` ← 1.

**Other rules**
- With `i_enable`=0, all registers hold. `o_stall` is still driven combinationally.
- The register file writes in the first half-cycle, so WB-stage producers need no forwarding path.

## Timing

- Reset values (asynchronous, immediate):
  - Both trackers invalid, rd fields 0.
  - `o_fwd_a_sel`=`o_fwd_b_sel`=00.
  - `o_ex_bubble`=1.
  - `o_stall`=0.
- Select latency: computed from the trackers in cycle n, registered at edge n+1, valid for the whole EX cycle n+1 at the mux.
- Load-use: exactly one stall cycle.
  - The stall clears the next cycle because `ex_valid` is 0 (bubble).
  - The load is then in MEM, so the dependent instruction enters EX with select 10.
- Back-to-back loads into the same register: each follower stalls once. There are no double stalls.
- Reset asserted mid-stall: `o_stall` drops at once and all selects return to 00.

## Test plan

1. **Reset:** assert `i_reset` with random inputs.
   - Selects stay 00, `o_ex_bubble`=1, `o_stall`=0.
   - After release, with `i_id_valid`=0, outputs hold these values.
2. **EX forward:** issue `add r3` (rw=1), then `sub` with rs=3 (used).
   - The cycle `sub` is in EX: `o_fwd_a_sel`=01, `o_fwd_b_sel`=00.
3. **MEM forward and priority:**
   - `add r4`, nop, `or` with rt=4: `o_fwd_b_sel`=10.
   - `add r4`, `add r4`, use rs=4: `o_fwd_a_sel`=01.
4. **Load-use:** `lw r5`, then `and` with rt=5.
   - `o_stall`=1 for exactly one cycle.
   - Next edge: `o_ex_bubble`=1.
   - When `and` enters EX: `o_fwd_b_sel`=10, `o_ex_bubble`=0.
5. **r0 and flush:**
   - `add r0`, then use rs=0: `o_fwd_a_sel`=11.
   - `lw r6` followed by a dependent instruction with `i_flush`=1: `o_stall`=0, next `o_ex_bubble`=1.
6. **Freeze:** during a pending EX forward, hold `i_enable`=0 for 3 cycles.
   - Selects, trackers and bubble are unchanged.
   - Resume: same selects as the unfrozen run.

Source files
------------

// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding select generation and load-use stall detection for the ID stage.
// Tracks the EX and MEM destinations and registers the mux4 selects used during EX.
module forwarding_hazard_unit #(
  parameter int NB_REG    = 5,
  parameter int NB_SELECT = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_id_valid,
  input  logic [NB_REG-1:0]    i_id_rs,
  input  logic [NB_REG-1:0]    i_id_rt,
  input  logic                 i_id_rs_used,
  input  logic                 i_id_rt_used,
  input  logic [NB_REG-1:0]    i_id_rd,
  input  logic                 i_id_reg_write,
  input  logic                 i_id_mem_read,
  input  logic                 i_flush,
  output logic                 o_stall,
  output logic [NB_SELECT-1:0] o_fwd_a_sel,
  output logic [NB_SELECT-1:0] o_fwd_b_sel,
  output logic                 o_ex_bubble
);

  localparam logic [NB_SELECT-1:0] SEL_RF    = NB_SELECT'(0);
  localparam logic [NB_SELECT-1:0] SEL_EXMEM = NB_SELECT'(1);
  localparam logic [NB_SELECT-1:0] SEL_MEMWB = NB_SELECT'(2);
  localparam logic [NB_SELECT-1:0] SEL_ZERO  = NB_SELECT'(3);

  logic              ex_valid, ex_rw, ex_mr;
  logic [NB_REG-1:0] ex_rd;
  logic              mem_valid, mem_rw;
  logic [NB_REG-1:0] mem_rd;

  logic [NB_SELECT-1:0] sel_a, sel_b;
  logic                 hazard, advance;

  // A load still in EX has no result yet, so it can only be forwarded from MEM/WB.
  function automatic logic [NB_SELECT-1:0] src_sel(
    input logic              used,
    input logic [NB_REG-1:0] s,
    input logic              exv,
    input logic              exw,
    input logic              exm,
    input logic [NB_REG-1:0] exd,
    input logic              memv,
    input logic              memw,
    input logic [NB_REG-1:0] memd
  );
    logic [NB_SELECT-1:0] r;
    r = SEL_RF;
    if (!used)
      r = SEL_RF;
    else if (s == '0)
      r = SEL_ZERO;
    else if (exv && exw && !exm && exd == s)
      r = SEL_EXMEM;
    else if (memv && memw && memd == s)
      r = SEL_MEMWB;
    return r;
  endfunction

  always_comb begin
    sel_a = src_sel(i_id_rs_used, i_id_rs, ex_valid, ex_rw, ex_mr, ex_rd,
                    mem_valid, mem_rw, mem_rd);
    sel_b = src_sel(i_id_rt_used, i_id_rt, ex_valid, ex_rw, ex_mr, ex_rd,
                    mem_valid, mem_rw, mem_rd);
    hazard = ex_valid && ex_mr && ex_rw && (ex_rd != '0) && i_id_valid &&
             ((i_id_rs_used && (i_id_rs != '0) && (i_id_rs == ex_rd)) ||
              (i_id_rt_used && (i_id_rt != '0) && (i_id_rt == ex_rd)));
    o_stall = hazard && !i_flush;
    advance = i_id_valid && !o_stall && !i_flush;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ex_valid    <= 1'b0;
      ex_rw       <= 1'b0;
      ex_mr       <= 1'b0;
      ex_rd       <= '0;
      mem_valid   <= 1'b0;
      mem_rw      <= 1'b0;
      mem_rd      <= '0;
      o_fwd_a_sel <= SEL_RF;
      o_fwd_b_sel <= SEL_RF;
      o_ex_bubble <= 1'b1;
    end else if (i_enable) begin
      mem_valid <= ex_valid;
      mem_rw    <= ex_rw;
      mem_rd    <= ex_rd;
      if (advance) begin
        ex_valid    <= 1'b1;
        ex_rw       <= i_id_reg_write;
        ex_mr       <= i_id_mem_read;
        ex_rd       <= i_id_rd;
        o_fwd_a_sel <= sel_a;
        o_fwd_b_sel <= sel_b;
        o_ex_bubble <= 1'b0;
      end else begin
        ex_valid    <= 1'b0;
        o_fwd_a_sel <= SEL_RF;
        o_fwd_b_sel <= SEL_RF;
        o_ex_bubble <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit: expected EX-cycle outputs are queued
// when an ID instruction is driven and compared after the following rising edge.
module tb_forwarding_hazard_unit;

  logic       i_clk = 1'b0;
  logic       i_reset, i_enable, i_id_valid;
  logic [4:0] i_id_rs, i_id_rt, i_id_rd;
  logic       i_id_rs_used, i_id_rt_used, i_id_reg_write, i_id_mem_read, i_flush;
  logic       o_stall, o_ex_bubble;
  logic [1:0] o_fwd_a_sel, o_fwd_b_sel;

  typedef struct {
    string      tag;
    logic [1:0] a;
    logic [1:0] b;
    logic       bub;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  forwarding_hazard_unit #(.NB_REG(5), .NB_SELECT(2)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_id_valid(i_id_valid),
    .i_id_rs(i_id_rs), .i_id_rt(i_id_rt), .i_id_rs_used(i_id_rs_used),
    .i_id_rt_used(i_id_rt_used), .i_id_rd(i_id_rd), .i_id_reg_write(i_id_reg_write),
    .i_id_mem_read(i_id_mem_read), .i_flush(i_flush), .o_stall(o_stall),
    .o_fwd_a_sel(o_fwd_a_sel), .o_fwd_b_sel(o_fwd_b_sel), .o_ex_bubble(o_ex_bubble)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one ID slot at the falling edge, check the combinational stall,
  // then compare the registered outputs after the rising edge.
  task automatic cyc(input string tag, input logic en, input logic v,
                     input logic [4:0] rs, input logic ru, input logic [4:0] rt, input logic tu,
                     input logic [4:0] rd, input logic rw, input logic mr, input logic fl,
                     input logic exp_stall, input logic [1:0] ea, input logic [1:0] eb,
                     input logic ebub);
    exp_t e;
    exp_t got;
    @(negedge i_clk);
    i_enable = en; i_id_valid = v; i_id_rs = rs; i_id_rs_used = ru;
    i_id_rt = rt; i_id_rt_used = tu; i_id_rd = rd; i_id_reg_write = rw;
    i_id_mem_read = mr; i_flush = fl;
    e.tag = tag; e.a = ea; e.b = eb; e.bub = ebub;
    exp_q.push_back(e);
    #1;
    chk({tag, "_stall"}, {7'd0, o_stall}, {7'd0, exp_stall});
    @(posedge i_clk);
    #1;
    got = exp_q.pop_front();
    chk({got.tag, "_a"},   {6'd0, o_fwd_a_sel}, {6'd0, got.a});
    chk({got.tag, "_b"},   {6'd0, o_fwd_b_sel}, {6'd0, got.b});
    chk({got.tag, "_bub"}, {7'd0, o_ex_bubble}, {7'd0, got.bub});
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
  endtask

  initial begin
    i_reset = 1'b1; i_enable = 1'b1; i_id_valid = 1'b0; i_id_rs = '0; i_id_rt = '0;
    i_id_rs_used = 1'b0; i_id_rt_used = 1'b0; i_id_rd = '0; i_id_reg_write = 1'b0;
    i_id_mem_read = 1'b0; i_flush = 1'b0;

    // reset held with random inputs
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      {i_enable, i_id_valid, i_id_rs_used, i_id_rt_used, i_id_reg_write, i_id_mem_read, i_flush} =
        7'($urandom);
      i_id_rs = 5'($urandom); i_id_rt = 5'($urandom); i_id_rd = 5'($urandom);
      @(posedge i_clk); #1;
      chk("rst_a",     {6'd0, o_fwd_a_sel}, 8'd0);
      chk("rst_b",     {6'd0, o_fwd_b_sel}, 8'd0);
      chk("rst_bub",   {7'd0, o_ex_bubble}, 8'd1);
      chk("rst_stall", {7'd0, o_stall},     8'd0);
    end
    @(negedge i_clk);
    i_reset = 1'b0;
    idle("post_rst0");
    idle("post_rst1");

    // EX forward: add r3; sub r8 <- r3, r7
    cyc("ex_add",  1, 1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc("ex_sub",  1, 1, 5'd3, 1, 5'd7, 1, 5'd8, 1, 0, 0, 0, 2'b01, 2'b00, 0);
    idle("ex_idle");

    // MEM forward: add r4; nop; or r10 <- r9, r4
    cyc("mem_add", 1, 1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    idle("mem_nop");
    cyc("mem_or",  1, 1, 5'd9, 1, 5'd4, 1, 5'd10, 1, 0, 0, 0, 2'b00, 2'b10, 0);

    // EX over MEM priority: add r4; add r4; use rs=4
    cyc("pri_add1", 1, 1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc("pri_add2", 1, 1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc("pri_use",  1, 1, 5'd4, 1, 5'd0, 0, 5'd11, 0, 0, 0, 0, 2'b01, 2'b00, 0);
    idle("pri_idle0");
    idle("pri_idle1");

    // load-use: lw r5; and r13 <- r1, r5 stalls once, then forwards from MEM/WB
    cyc("lu_lw",     1, 1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0, 0, 2'b00, 2'b00, 0);
    cyc("lu_stall",  1, 1, 5'd1, 1, 5'd5, 1, 5'd13, 1, 0, 0, 1, 2'b00, 2'b00, 1);
    cyc("lu_and",    1, 1, 5'd1, 1, 5'd5, 1, 5'd13, 1, 0, 0, 0, 2'b00, 2'b10, 0);
    idle("lu_idle0");
    idle("lu_idle1");

    // back-to-back loads into r6: each follower stalls exactly once
    cyc("bb_lw1",    1, 1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 1, 0, 0, 2'b00, 2'b00, 0);
    cyc("bb_st1",    1, 1, 5'd6, 1, 5'd0, 0, 5'd6, 1, 1, 0, 1, 2'b00, 2'b00, 1);
    cyc("bb_lw2",    1, 1, 5'd6, 1, 5'd0, 0, 5'd6, 1, 1, 0, 0, 2'b10, 2'b00, 0);
    cyc("bb_st2",    1, 1, 5'd2, 1, 5'd6, 1, 5'd14, 1, 0, 0, 1, 2'b00, 2'b00, 1);
    cyc("bb_use",    1, 1, 5'd2, 1, 5'd6, 1, 5'd14, 1, 0, 0, 0, 2'b00, 2'b10, 0);
    idle("bb_idle0");
    idle("bb_idle1");

    // r0: add r0 never forwards, source r0 selects constant zero
    cyc("r0_add",    1, 1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc("r0_use",    1, 1, 5'd0, 1, 5'd0, 0, 5'd15, 1, 0, 0, 0, 2'b11, 2'b00, 0);
    idle("r0_idle0");
    idle("r0_idle1");

    // flush beats load-use stall
    cyc("fl_lw",     1, 1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 1, 0, 0, 2'b00, 2'b00, 0);
    cyc("fl_dep",    1, 1, 5'd6, 1, 5'd0, 0, 5'd16, 1, 0, 1, 0, 2'b00, 2'b00, 1);
    idle("fl_idle0");
    idle("fl_idle1");

    // freeze: add r12 (rs=r0 -> 11) in EX, sub <- r12 pending in ID for 3 frozen cycles
    cyc("fz_add",    1, 1, 5'd0, 1, 5'd0, 0, 5'd12, 1, 0, 0, 0, 2'b11, 2'b00, 0);
    for (int k = 0; k < 3; k++)
      cyc("fz_hold", 0, 1, 5'd12, 1, 5'd0, 0, 5'd17, 1, 0, 0, 0, 2'b11, 2'b00, 0);
    cyc("fz_resume", 1, 1, 5'd12, 1, 5'd0, 0, 5'd17, 1, 0, 0, 0, 2'b01, 2'b00, 0);
    idle("fz_idle0");
    idle("fz_idle1");

    // reset mid-stall: lw r7 (rs=r0 -> 11), dependent stalls, reset clears at once
    cyc("rs_lw",     1, 1, 5'd0, 1, 5'd0, 0, 5'd7, 1, 1, 0, 0, 2'b11, 2'b00, 0);
    @(negedge i_clk);
    i_enable = 1'b1; i_id_valid = 1'b1; i_id_rs = 5'd7; i_id_rs_used = 1'b1;
    i_id_rt = 5'd0; i_id_rt_used = 1'b0; i_id_rd = 5'd18; i_id_reg_write = 1'b1;
    i_id_mem_read = 1'b0; i_flush = 1'b0;
    #1;
    chk("rs_stall_pre", {7'd0, o_stall}, 8'd1);
    i_reset = 1'b1;
    #1;
    chk("rs_stall",   {7'd0, o_stall},     8'd0);
    chk("rs_a",       {6'd0, o_fwd_a_sel}, 8'd0);
    chk("rs_b",       {6'd0, o_fwd_b_sel}, 8'd0);
    chk("rs_bub",     {7'd0, o_ex_bubble}, 8'd1);
    @(negedge i_clk);
    i_reset = 1'b0;
    cyc("rs_after",  1, 1, 5'd7, 1, 5'd0, 0, 5'd18, 1, 0, 0, 0, 2'b00, 2'b00, 0);

    chk("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
